bus_sequencer: RTL and testbench
================================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 The module SHALL have one clock, `clock`, and a reset, `reset`, that is synchronous and active-high.
REQ-002 Ports: clock  in  1  system clock; one bus subcycle per clock.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 data  inout  4  shared nibble bus to rom instances.
REQ-005 sync  out  1  high during subcycle 7 only.
REQ-006 cmd  out  1  active-low command strobe to rom.
REQ-007 run  in  1  fetch enable, sampled at end of subcycle 7.
REQ-008 jump_valid  in  1  request to load the PC at the next boundary.
REQ-009 jump_addr  in  12  target PC.
REQ-010 src_req / src_id  in  1 / 4  request an SRC chip-select, with its chip id.
REQ-011 io_req / io_data  in  1 / 4  request an I/O write, with its data nibble.
REQ-012 src_ack / io_ack  out  1 / 1  one-cycle grant pulses.
REQ-013 pc  out  12  address of the current instruction cycle.
REQ-014 fetch_valid  out  1  one-cycle pulse; opr/opa are fresh.
REQ-015 opr / opa  out  4 / 4  fetched high and low instruction nibbles.

Function
REQ-016 A 3-bit subcycle counter SHALL free-run 0..7 and wrap 7->0, with no stall; it stays aligned with every rom instance's counter.
REQ-017 Subcycles 0, 1 and 2 SHALL drive data with pc[3:0], pc[7:4] and pc[11:8] respectively, every instruction cycle, active or not.
REQ-018 Subcycles 3, 4, 5 and 7 SHALL leave data high-Z.
REQ-019 Subcycle 6 SHALL drive data only when a granted action is pending (REQ-026, REQ-027); otherwise data is high-Z.
REQ-020 An `active` flag SHALL load from run at the end of subcycle 7 and hold for the whole next instruction cycle.
REQ-021 If active, opr SHALL capture data at the end of subcycle 3, and opa SHALL capture data at the end of subcycle 4.
REQ-022 If active, fetch_valid SHALL be high during subcycle 5 only; opr and opa hold until the next capture.
REQ-023 At the end of subcycle 7, pc update priority SHALL be:
- jump_valid: pc <= jump_addr (applies even when not active);
- else if active: pc <= pc+1, modulo 4096 (0xFFF -> 0x000);
- else pc holds.
REQ-024 jump_valid SHALL be ignored in subcycles 0-6; the requester holds it until the end of subcycle 7.
REQ-025 src_req and io_req SHALL be sampled at the end of subcycle 7; at most one is granted per instruction cycle; src has priority; an ungranted request must be held by its requester.
REQ-026 SRC grant: src_ack SHALL pulse during subcycle 0; during subcycle 6, cmd=0 and data=latched src_id.
REQ-027 IO grant: io_ack SHALL pulse during subcycle 0; during subcycles 4 and 6, cmd=0; during subcycle 6, data=latched io_data.
REQ-028 cmd SHALL be 1 in all other subcycles.
REQ-029 Grants SHALL be independent of active, so that port writes work while fetch is halted.
REQ-030 The src_id and io_data values SHALL be latched at the grant, so requester changes after the grant have no effect.
REQ-031 run deasserted mid-cycle SHALL take effect only at the next subcycle-7 boundary; the current fetch completes.

Reset
REQ-032 When reset is asserted, the following SHALL hold on the next clock edge:
- subcycle=0, pc=0x000, active=0, no grant pending;
- opr=0, opa=0, fetch_valid=0;
- sync=0, cmd=1, src_ack=0, io_ack=0;
- data high-Z.
REQ-033 Reset asserted mid-instruction-cycle SHALL abort any pending grant; no cmd low pulse and no data drive occur after the reset edge.
REQ-034 The first subcycle after reset release SHALL be subcycle 0; the first fetch occurs in the second instruction cycle if run=1.

Verification
REQ-035 Scenario: rom[0x000]=0xE2, rom[0x001]=0x5A, run=1 from reset -> fetch_valid in subcycle 5 with opr=E, opa=2; next instruction cycle gives opr=5, opa=A; pc steps 0x000, 0x001, 0x002.
REQ-036 Scenario: pc=0xFFF, active -> after the subcycle-7 boundary, pc=0x000, and data shows 0, 0, 0 in subcycles 0-2.
REQ-037 Scenario: jump_valid=1 with jump_addr=0x3C7, asserted at subcycle 7 -> next instruction cycle drives 7, C, 3, and fetches rom[0x3C7].
REQ-038 Scenario: src_req with src_id=0 and io_req with io_data=0x9 in the same cycle, with the rom holding 0xE2 -> src_ack first, cmd=0 at subcycle 6 only; next instruction cycle io_ack, cmd=0 at subcycles 4 and 6; rom io then reads 0x9.
REQ-039 Scenario: run=0 -> no fetch_valid, pc frozen, and sync still pulses every 8 clocks.
REQ-040 Scenario: reset asserted at subcycle 5 of an io grant -> cmd stays 1 and data stays high-Z; pc=0 after release.

Source files
------------

// File: rtl/bus_sequencer.sv
// bus_sequencer: drives the shared nibble bus for an 8-subcycle instruction
// cycle, fetches opr/opa from the rom, steps or loads the PC, and issues one
// SRC or I/O port action per instruction cycle.
module bus_sequencer (
   input  logic        clock,
   input  logic        reset,
   inout  wire  [3:0]  data,
   output logic        sync,
   output logic        cmd,
   input  logic        run,
   input  logic        jump_valid,
   input  logic [11:0] jump_addr,
   input  logic        src_req,
   input  logic [3:0]  src_id,
   input  logic        io_req,
   input  logic [3:0]  io_data,
   output logic        src_ack,
   output logic        io_ack,
   output logic [11:0] pc,
   output logic        fetch_valid,
   output logic [3:0]  opr,
   output logic [3:0]  opa
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_SRC  = 2'd1,
      GNT_IO   = 2'd2
   } gnt_e;

   // Sequencing state.
   logic        hold_q,   hold_d;    // first clock after reset: stay in subcycle 0
   logic [2:0]  sub_q,    sub_d;
   logic [11:0] pc_q,     pc_d;
   logic        active_q, active_d;
   gnt_e        gnt_q,    gnt_d;
   logic [3:0]  gdata_q,  gdata_d;   // src_id / io_data latched at grant time
   logic [3:0]  opr_q,    opr_d;
   logic [3:0]  opa_q,    opa_d;

   // Registered outputs, computed from the next-state values so they line up
   // with the subcycle they belong to.
   logic        sync_q,   sync_d;
   logic        cmd_q,    cmd_d;
   logic        oe_q,     oe_d;
   logic [3:0]  dout_q,   dout_d;
   logic        src_ack_q, src_ack_d;
   logic        io_ack_q,  io_ack_d;
   logic        fv_q,     fv_d;

   logic        boundary;            // this edge ends subcycle 7

   // Next-state and next-output decode.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a latch.
      hold_d    = 1'b0;
      sub_d     = hold_q ? 3'd0 : sub_q + 3'd1;
      pc_d      = pc_q;
      active_d  = active_q;
      gnt_d     = gnt_q;
      gdata_d   = gdata_q;
      opr_d     = opr_q;
      opa_d     = opa_q;
      boundary  = (sub_q == 3'd7);

      if (boundary) begin
         active_d = run;
         if (jump_valid)    pc_d = jump_addr;
         else if (active_q) pc_d = pc_q + 12'd1;
         gnt_d = GNT_NONE;
         if (src_req) begin
            gnt_d   = GNT_SRC;
            gdata_d = src_id;
         end else if (io_req) begin
            gnt_d   = GNT_IO;
            gdata_d = io_data;
         end
      end

      if (active_q && sub_q == 3'd3) opr_d = data;
      if (active_q && sub_q == 3'd4) opa_d = data;

      sync_d    = (sub_d == 3'd7);
      fv_d      = active_d && (sub_d == 3'd5);
      src_ack_d = (sub_d == 3'd0) && (gnt_d == GNT_SRC);
      io_ack_d  = (sub_d == 3'd0) && (gnt_d == GNT_IO);
      cmd_d     = !(((sub_d == 3'd6) && (gnt_d != GNT_NONE)) ||
                    ((sub_d == 3'd4) && (gnt_d == GNT_IO)));
      oe_d      = 1'b0;
      dout_d    = 4'h0;
      case (sub_d)
         3'd0: begin oe_d = 1'b1; dout_d = pc_d[3:0];  end
         3'd1: begin oe_d = 1'b1; dout_d = pc_d[7:4];  end
         3'd2: begin oe_d = 1'b1; dout_d = pc_d[11:8]; end
         3'd6: begin oe_d = (gnt_d != GNT_NONE); dout_d = gdata_d; end
         default: ;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         hold_q    <= 1'b1;
         sub_q     <= 3'd0;
         pc_q      <= 12'h000;
         active_q  <= 1'b0;
         gnt_q     <= GNT_NONE;
         gdata_q   <= 4'h0;
         opr_q     <= 4'h0;
         opa_q     <= 4'h0;
         sync_q    <= 1'b0;
         cmd_q     <= 1'b1;
         oe_q      <= 1'b0;
         dout_q    <= 4'h0;
         src_ack_q <= 1'b0;
         io_ack_q  <= 1'b0;
         fv_q      <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         sub_q     <= sub_d;
         pc_q      <= pc_d;
         active_q  <= active_d;
         gnt_q     <= gnt_d;
         gdata_q   <= gdata_d;
         opr_q     <= opr_d;
         opa_q     <= opa_d;
         sync_q    <= sync_d;
         cmd_q     <= cmd_d;
         oe_q      <= oe_d;
         dout_q    <= dout_d;
         src_ack_q <= src_ack_d;
         io_ack_q  <= io_ack_d;
         fv_q      <= fv_d;
      end
   end

   assign data        = oe_q ? dout_q : 4'bzzzz;
   assign sync        = sync_q;
   assign cmd         = cmd_q;
   assign src_ack     = src_ack_q;
   assign io_ack      = io_ack_q;
   assign pc          = pc_q;
   assign fetch_valid = fv_q;
   assign opr         = opr_q;
   assign opa         = opa_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: rom/port model on the shared bus plus scenario tasks.
// Fetches and port writes are predicted into queues and retired by monitors.
module tb_bus_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0, jump_valid = 1'b0;
   logic [11:0] jump_addr = 12'h000;
   logic        src_req = 1'b0, io_req = 1'b0;
   logic [3:0]  src_id = 4'h0, io_data = 4'h0;
   tri1  [3:0]  data;                 // released bus reads as 4'hF
   logic        sync, cmd, src_ack, io_ack, fetch_valid;
   logic [11:0] pc;
   logic [3:0]  opr, opa;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed { logic [11:0] pc; logic [3:0] opr; logic [3:0] opa; } fetch_t;
   typedef struct packed { logic is_io; logic [3:0] value; } port_t;
   fetch_t fq[$];
   port_t  pq[$];

   bus_sequencer dut (
      .clock(clock), .reset(reset), .data(data), .sync(sync), .cmd(cmd),
      .run(run), .jump_valid(jump_valid), .jump_addr(jump_addr),
      .src_req(src_req), .src_id(src_id), .io_req(io_req), .io_data(io_data),
      .src_ack(src_ack), .io_ack(io_ack), .pc(pc), .fetch_valid(fetch_valid),
      .opr(opr), .opa(opa)
   );

   always #5 clock = ~clock;

   // Rom model: aligns to sync, latches the address in subcycles 0-2,
   // drives the instruction byte in subcycles 3-4, snoops port commands.
   logic [7:0]  rom_mem [0:4095];
   logic        rom_ok = 1'b0, rom_io = 1'b0;
   logic [2:0]  rom_sub = 3'd0;
   logic [11:0] rom_addr = 12'h000;
   logic        rom_oe;
   logic [3:0]  rom_dout;

   always_comb begin
      rom_oe   = rom_ok && (rom_sub == 3'd3 || rom_sub == 3'd4);
      rom_dout = (rom_sub == 3'd3) ? rom_mem[rom_addr][7:4] : rom_mem[rom_addr][3:0];
   end
   assign data = rom_oe ? rom_dout : 4'bzzzz;

   always @(posedge clock) begin
      if (reset) begin
         rom_ok <= 1'b0; rom_sub <= 3'd0; rom_io <= 1'b0;
      end else if (sync === 1'b1) begin
         rom_ok <= 1'b1; rom_sub <= 3'd0; rom_io <= 1'b0;
      end else begin
         rom_sub <= rom_sub + 3'd1;
         if (rom_ok) begin
            case (rom_sub)
               3'd0: rom_addr[3:0]  <= data;
               3'd1: rom_addr[7:4]  <= data;
               3'd2: rom_addr[11:8] <= data;
               3'd4: if (cmd === 1'b0) rom_io <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Fetch monitor: every fetch_valid pulse retires one predicted fetch.
   always @(negedge clock) begin
      fetch_t e;
      if (fetch_valid === 1'b1) begin
         vectors++;
         if (fq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_fetch: got pc=%h opr=%h opa=%h, none expected", pc, opr, opa);
         end else begin
            e = fq.pop_front();
            if ({pc, opr, opa, rom_sub} !== {e.pc, e.opr, e.opa, 3'd5}) begin
               miscompares++;
               $display("FAIL fetch: got pc=%h opr=%h opa=%h sub=%0d, want pc=%h opr=%h opa=%h sub=5",
                        pc, opr, opa, rom_sub, e.pc, e.opr, e.opa);
            end
         end
      end
   end

   // Port monitor: a command in subcycle 6 retires one predicted port write.
   always @(negedge clock) begin
      port_t p;
      if (rom_ok && rom_sub == 3'd6 && cmd === 1'b0) begin
         vectors++;
         if (pq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_port: got io=%b data=%h, none expected", rom_io, data);
         end else begin
            p = pq.pop_front();
            if ({rom_io, data} !== {p.is_io, p.value}) begin
               miscompares++;
               $display("FAIL port_write: got io=%b data=%h, want io=%b data=%h",
                        rom_io, data, p.is_io, p.value);
            end
         end
      end
   end

   task automatic reset_dut();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_sync();
      int n = 0;
      do begin @(negedge clock); n++; end while (sync !== 1'b1 && n < 20);
      if (sync !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL wait_sync: got no sync within 20 clocks, want a pulse");
      end
   endtask

   task automatic goto_sub(input int s);
      int n = 0;
      do begin @(negedge clock); n++; end
      while (!(rom_ok === 1'b1 && int'(rom_sub) == s) && n < 20);
      if (!(rom_ok === 1'b1 && int'(rom_sub) == s)) begin
         vectors++; miscompares++;
         $display("FAIL goto_sub: got no subcycle %0d within 20 clocks", s);
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_d;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      vectors++;
      if ({sync, cmd, src_ack, io_ack, fetch_valid} !== 5'b01000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got sync/cmd/sack/iack/fv=%b want 01000",
                  {sync, cmd, src_ack, io_ack, fetch_valid});
      end
      vectors++;
      if ({pc, opr, opa} !== 20'h00000) begin
         miscompares++;
         $display("FAIL reset_regs: got pc=%h opr=%h opa=%h want all zero", pc, opr, opa);
      end
      vectors++;
      if (data !== 4'hF) begin
         miscompares++;
         $display("FAIL reset_bus: got %h want released (F)", data);
      end
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         exp_d = (i < 3) ? 4'h0 : 4'hF;
         vectors++;
         if (sync !== 1'(i == 7)) begin
            miscompares++;
            $display("FAIL post_reset_sync[%0d]: got %b want %b", i, sync, 1'(i == 7));
         end
         vectors++;
         if (data !== exp_d) begin
            miscompares++;
            $display("FAIL post_reset_bus[%0d]: got %h want %h", i, data, exp_d);
         end
      end
   endtask

   // Runs from reset: fetch 0x000 and 0x001, then halt.
   task automatic test_fetch();
      logic [11:0] exp_pc [3] = '{12'h000, 12'h001, 12'h002};
      run = 1'b1;
      fq.push_back('{12'h000, 4'hE, 4'h2});
      fq.push_back('{12'h001, 4'h5, 4'hA});
      reset_dut();
      wait_sync();
      for (int c = 0; c < 3; c++) begin
         if (c == 2) run = 1'b0;
         goto_sub(0);
         vectors++;
         if ({pc, data} !== {exp_pc[c], exp_pc[c][3:0]}) begin
            miscompares++;
            $display("FAIL fetch_pc[%0d]: got pc=%h bus=%h want pc=%h bus=%h",
                     c, pc, data, exp_pc[c], exp_pc[c][3:0]);
         end
         if (c < 2) goto_sub(7);
      end
      vectors++;
      if (fq.size() != 0) begin
         miscompares++;
         $display("FAIL fetch_drain: got %0d pending want 0", fq.size());
      end
   endtask

   // Jump to 0xFFF while running; the increment must wrap to 0x000.
   task automatic test_wrap();
      goto_sub(7);
      jump_valid = 1'b1; jump_addr = 12'hFFF; run = 1'b1;
      fq.push_back('{12'hFFF, 4'h3, 4'hB});
      goto_sub(0);
      vectors++;
      if (pc !== 12'hFFF) begin
         miscompares++;
         $display("FAIL wrap_pre: got pc=%h want FFF", pc);
      end
      goto_sub(7);
      jump_valid = 1'b0;
      fq.push_back('{12'h000, 4'hE, 4'h2});
      for (int s = 0; s < 3; s++) begin
         goto_sub(s);
         vectors++;
         if ({pc, data} !== {12'h000, 4'h0}) begin
            miscompares++;
            $display("FAIL wrap_bus[%0d]: got pc=%h bus=%h want pc=000 bus=0", s, pc, data);
         end
      end
      goto_sub(7);
      run = 1'b0;
   endtask

   // jump_valid outside subcycle 7 must not move the PC.
   task automatic test_jump_ignored();
      goto_sub(1);
      jump_valid = 1'b1; jump_addr = 12'h123;
      goto_sub(6);
      jump_valid = 1'b0;
      goto_sub(0);
      vectors++;
      if (pc !== 12'h001) begin
         miscompares++;
         $display("FAIL jump_ignored: got pc=%h want 001", pc);
      end
   endtask

   task automatic test_jump();
      logic [3:0] exp_n [3] = '{4'h7, 4'hC, 4'h3};
      goto_sub(7);
      jump_valid = 1'b1; jump_addr = 12'h3C7; run = 1'b1;
      fq.push_back('{12'h3C7, 4'h4, 4'hD});
      for (int s = 0; s < 3; s++) begin
         goto_sub(s);
         vectors++;
         if ({pc, data} !== {12'h3C7, exp_n[s]}) begin
            miscompares++;
            $display("FAIL jump_bus[%0d]: got pc=%h bus=%h want pc=3C7 bus=%h", s, pc, data, exp_n[s]);
         end
      end
      goto_sub(7);
      jump_valid = 1'b0; run = 1'b0;
   endtask

   // Simultaneous SRC and I/O requests while halted: SRC first, then I/O.
   task automatic test_grants();
      logic [1:0] exp_ack;
      logic       exp_cmd;
      goto_sub(7);
      src_req = 1'b1; src_id = 4'h0; io_req = 1'b1; io_data = 4'h9;
      pq.push_back('{1'b0, 4'h0});
      for (int c = 0; c < 3; c++) begin
         for (int s = 0; s < 8; s++) begin
            @(negedge clock);
            exp_ack = (s != 0) ? 2'b00 : (c == 0) ? 2'b10 : (c == 1) ? 2'b01 : 2'b00;
            exp_cmd = !((c < 2 && s == 6) || (c == 1 && s == 4));
            vectors++;
            if ({src_ack, io_ack, cmd} !== {exp_ack, exp_cmd}) begin
               miscompares++;
               $display("FAIL grant[%0d][%0d]: got sack/iack/cmd=%b want %b",
                        c, s, {src_ack, io_ack, cmd}, {exp_ack, exp_cmd});
            end
            if (s == 6 && c < 2) begin
               vectors++;
               if (data !== ((c == 0) ? 4'h0 : 4'h9)) begin
                  miscompares++;
                  $display("FAIL grant_data[%0d]: got %h want %h", c, data, (c == 0) ? 4'h0 : 4'h9);
               end
            end
            if (s == 0 && c == 0) begin src_req = 1'b0; src_id = 4'hF; end
            if (s == 0 && c == 1) begin io_req = 1'b0; io_data = 4'h5; end
            if (s == 7 && c == 0) pq.push_back('{1'b1, 4'h9});
         end
      end
   endtask

   task automatic test_halt();
      for (int i = 0; i < 24; i++) begin
         @(negedge clock);
         vectors++;
         if ({sync, pc, fetch_valid} !== {1'((i % 8) == 7), 12'h3C8, 1'b0}) begin
            miscompares++;
            $display("FAIL halt[%0d]: got sync=%b pc=%h fv=%b want sync=%b pc=3C8 fv=0",
                     i, sync, pc, fetch_valid, 1'((i % 8) == 7));
         end
      end
   endtask

   // Reset in subcycle 5 of an I/O grant aborts the subcycle-6 command.
   task automatic test_reset_mid_io();
      io_req = 1'b1; io_data = 4'h6;
      @(negedge clock);
      vectors++;
      if (io_ack !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_io_ack: got %b want 1", io_ack);
      end
      io_req = 1'b0;
      goto_sub(5);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         vectors++;
         if ({cmd, data} !== {1'b1, 4'hF}) begin
            miscompares++;
            $display("FAIL mid_reset[%0d]: got cmd=%b bus=%h want cmd=1 bus=F", i, cmd, data);
         end
      end
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if ({pc, data} !== {12'h000, 4'h0}) begin
         miscompares++;
         $display("FAIL mid_release: got pc=%h bus=%h want pc=000 bus=0", pc, data);
      end
      for (int i = 1; i < 8; i++) begin
         @(negedge clock);
         vectors++;
         if (cmd !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_after[%0d]: got cmd=%b want 1", i, cmd);
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) rom_mem[a] = 8'h00;
      rom_mem[12'h000] = 8'hE2;
      rom_mem[12'h001] = 8'h5A;
      rom_mem[12'h002] = 8'h71;
      rom_mem[12'hFFF] = 8'h3B;
      rom_mem[12'h3C7] = 8'h4D;

      test_reset();
      test_fetch();
      test_wrap();
      test_jump_ignored();
      test_jump();
      test_grants();
      test_halt();
      test_reset_mid_io();

      vectors++;
      if (fq.size() != 0 || pq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d fetches %0d port writes pending want 0", fq.size(), pq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000 time units");
      $fatal(1);
   end

endmodule
